conv_sequencer: RTL
===================

Name: conv_sequencer

Overview:
- Top-level sequencer for the convolution datapath: capture, send, then the PE, SA_3x3 and SA_2x2 engines, then display.
- Adds a per-run engine-enable mask, per-stage timeout and error state, and per-engine cycle counts.
- Cross-checks that all enabled engines produce the same 2x2 result (c11..c22).
- Drives the one-hot state enables consumed by memory, core_module and display.

Parameters:
TIMEOUT, 64, max cycles any waiting state may last before error; 2..255
CNT_W, 8, width of cycle-count outputs; 2^CNT_W-1 >= TIMEOUT

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
run  in  1  start request, level-sampled in IDLE
mode_mask  in  3  engine enables: bit0 PE, bit1 SA_3x3, bit2 SA_2x2
display_ack  in  1  leaves DISPLAY
clear  in  1  leaves ERROR
done_capture, done_send, done_PE, done_SA_3x3, done_SA_2x2  in  1 each  stage completion
c11, c12, c21, c22  in  8 each  shared result bus from core_module
state_idle, state_capture, state_send, state_PE, state_SA_3x3, state_SA_2x2, state_display  out  1 each  one-hot stage enables
current_state  out  3  encoded state
busy  out  1  high in CAPTURE..SA_2x2
done  out  1  one-cycle pulse on entry to DISPLAY
error_code  out  2  00 none, 01 empty mask, 10 timeout
mismatch  out  1  sticky, engine results disagree
cycles_PE, cycles_3x3, cycles_2x2  out  CNT_W each  latched engine latency

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; state_idle=1; all other outputs 0.
  - Internal reference registers, the mismatch flag and all counters clear.
  - This applies from any state, including mid-run.
- State encoding (current_state): IDLE 0, CAPTURE 1, SEND 2, PE 3, SA3 4, SA2 5, DISPLAY 6, ERROR 7.
  - Exactly one state_* is high in states 0-6. All state_* are 0 in ERROR.
- IDLE, run=1:
  - Latch mode_mask.
  - Clear mismatch, error_code and all cycles_*.
  - If mask==0, go to ERROR with error_code=01. Otherwise go to CAPTURE.
- CAPTURE: on done_capture go to SEND.
- SEND: on done_send go to the first enabled engine, in order PE, SA3, SA2.
- Engine states (PE/SA3/SA2):
  - The stage counter is 1 in the first cycle of the state and increments each cycle.
  - On that engine's done: latch the counter into cycles_*. A done in the first cycle gives 1.
  - First enabled engine: store c11..c22 as the reference.
  - Later engines: if any byte differs from the reference, set mismatch (sticky).
  - Then move to the next enabled engine, or to DISPLAY if none remain.
  - Disabled engines are skipped and their cycles_* stay 0.
- Timeout:
  - Applies in CAPTURE, SEND and the engine states.
  - If the stage counter reaches TIMEOUT without the expected done, go to ERROR with error_code=10 next cycle.
  - If done and the timeout occur in the same cycle, done wins.
- Only the done matching the current state is honoured. All other done_* inputs are ignored, including simultaneous ones.
- DISPLAY:
  - done pulses for 1 cycle on entry.
  - Stay until display_ack=1, then go to IDLE.
  - mismatch and cycles_* hold until the next run.
- ERROR:
  - busy=0; error_code holds.
  - clear=1 goes to IDLE and zeroes error_code.
  - run is ignored in ERROR.
- The stage counter resets to 1 on every state change.
- All outputs are registered, or decoded directly from the state register.
- Latency from run to state_capture is 1 cycle.

Test Plan:
- Mask=111; done_capture at cycle 2; done_send at 3; done_PE after 4 cycles, done_SA_3x3 after 9, done_SA_2x2 after 6; all c=8'h12,34,56,78 -> order CAPTURE,SEND,PE,SA3,SA2,DISPLAY; cycles 4/9/6; mismatch=0; done pulses once; display_ack returns to IDLE.
- Mask=010 -> SEND goes directly to SA3, then DISPLAY; cycles_PE=0, cycles_2x2=0.
- Mask=101; SA2 returns c22=8'h79 vs PE's 8'h78 -> mismatch=1 in DISPLAY; cleared on the next run.
- Mask=111; done_SA_3x3 never asserted, TIMEOUT=64 -> ERROR 64 cycles after entry; error_code=10; state_* all 0; clear -> IDLE, error_code=00.
- Mask=000 with run -> ERROR, error_code=01; done_PE pulse in SEND is ignored; reset=0 mid-SA3 -> IDLE immediately (async), all outputs 0.

Source files
------------

// File: rtl/conv_sequencer.sv
// Top-level sequencer for the convolution datapath.
// The stages run in a fixed order: capture, send, the enabled engines (PE, SA_3x3, SA_2x2),
// then display. Each waiting stage has a timeout. The sequencer records each engine's latency
// and checks that every enabled engine returns the same 2x2 result.
module conv_sequencer #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [2:0]       mode_mask,
    input  logic             display_ack,
    input  logic             clear,
    input  logic             done_capture,
    input  logic             done_send,
    input  logic             done_PE,
    input  logic             done_SA_3x3,
    input  logic             done_SA_2x2,
    input  logic [7:0]       c11,
    input  logic [7:0]       c12,
    input  logic [7:0]       c21,
    input  logic [7:0]       c22,
    output logic             state_idle,
    output logic             state_capture,
    output logic             state_send,
    output logic             state_PE,
    output logic             state_SA_3x3,
    output logic             state_SA_2x2,
    output logic             state_display,
    output logic [2:0]       current_state,
    output logic             busy,
    output logic             done,
    output logic [1:0]       error_code,
    output logic             mismatch,
    output logic [CNT_W-1:0] cycles_PE,
    output logic [CNT_W-1:0] cycles_3x3,
    output logic [CNT_W-1:0] cycles_2x2
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCapture = 3'd1,
        StSend    = 3'd2,
        StPe      = 3'd3,
        StSa3     = 3'd4,
        StSa2     = 3'd5,
        StDisplay = 3'd6,
        StError   = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      ref_q, ref_d;
    logic             mismatch_q, mismatch_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] cyc_pe_q, cyc_pe_d;
    logic [CNT_W-1:0] cyc_3_q, cyc_3_d;
    logic [CNT_W-1:0] cyc_2_q, cyc_2_d;
    logic             done_q, done_d;

    logic [31:0] result;
    logic        timed_out;
    state_e      nxt_after_sa3, nxt_after_pe, nxt_after_send;

    assign result    = {c11, c12, c21, c22};
    assign timed_out = (cnt_q >= CNT_W'(TIMEOUT));

    // Next enabled engine after each point in the chain
    always_comb begin
        nxt_after_sa3  = mask_q[2] ? StSa2 : StDisplay;
        nxt_after_pe   = mask_q[1] ? StSa3 : nxt_after_sa3;
        nxt_after_send = mask_q[0] ? StPe  : nxt_after_pe;
    end

    // Next-state, timeout, latency latching and result cross-check
    always_comb begin
        logic waiting;
        logic stage_done;
        logic eng_done;
        logic first_eng;

        state_d    = state_q;
        mask_d     = mask_q;
        ref_d      = ref_q;
        mismatch_d = mismatch_q;
        err_d      = err_q;
        cyc_pe_d   = cyc_pe_q;
        cyc_3_d    = cyc_3_q;
        cyc_2_d    = cyc_2_q;
        waiting    = 1'b0;
        stage_done = 1'b0;
        eng_done   = 1'b0;
        first_eng  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    mask_d     = mode_mask;
                    mismatch_d = 1'b0;
                    err_d      = 2'b00;
                    cyc_pe_d   = '0;
                    cyc_3_d    = '0;
                    cyc_2_d    = '0;
                    if (mode_mask == 3'b000) begin
                        state_d = StError;
                        err_d   = 2'b01;
                    end else begin
                        state_d = StCapture;
                    end
                end
            end
            StCapture: begin
                waiting    = 1'b1;
                stage_done = done_capture;
                if (done_capture) state_d = StSend;
            end
            StSend: begin
                waiting    = 1'b1;
                stage_done = done_send;
                if (done_send) state_d = nxt_after_send;
            end
            StPe: begin
                waiting    = 1'b1;
                stage_done = done_PE;
                first_eng  = 1'b1;
                if (done_PE) begin
                    cyc_pe_d = cnt_q;
                    eng_done = 1'b1;
                    state_d  = nxt_after_pe;
                end
            end
            StSa3: begin
                waiting    = 1'b1;
                stage_done = done_SA_3x3;
                first_eng  = ~mask_q[0];
                if (done_SA_3x3) begin
                    cyc_3_d  = cnt_q;
                    eng_done = 1'b1;
                    state_d  = nxt_after_sa3;
                end
            end
            StSa2: begin
                waiting    = 1'b1;
                stage_done = done_SA_2x2;
                first_eng  = (mask_q[1:0] == 2'b00);
                if (done_SA_2x2) begin
                    cyc_2_d  = cnt_q;
                    eng_done = 1'b1;
                    state_d  = StDisplay;
                end
            end
            StDisplay: begin
                if (display_ack) state_d = StIdle;
            end
            StError: begin
                if (clear) begin
                    state_d = StIdle;
                    err_d   = 2'b00;
                end
            end
        endcase

        // A done arriving in the timeout cycle still wins
        if (waiting && !stage_done && timed_out) begin
            state_d = StError;
            err_d   = 2'b10;
        end

        if (eng_done) begin
            if (first_eng) begin
                ref_d = result;
            end else if (result != ref_q) begin
                mismatch_d = 1'b1;
            end
        end

        // Stage counter: 1 in the first cycle of every state, saturating
        if (state_d != state_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        done_d = (state_d == StDisplay) && (state_q != StDisplay);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            cnt_q      <= '0;
            ref_q      <= '0;
            mismatch_q <= 1'b0;
            err_q      <= 2'b00;
            cyc_pe_q   <= '0;
            cyc_3_q    <= '0;
            cyc_2_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            ref_q      <= ref_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            cyc_pe_q   <= cyc_pe_d;
            cyc_3_q    <= cyc_3_d;
            cyc_2_q    <= cyc_2_d;
            done_q     <= done_d;
        end
    end

    // Outputs decoded straight from registers
    always_comb begin
        state_idle    = (state_q == StIdle);
        state_capture = (state_q == StCapture);
        state_send    = (state_q == StSend);
        state_PE      = (state_q == StPe);
        state_SA_3x3  = (state_q == StSa3);
        state_SA_2x2  = (state_q == StSa2);
        state_display = (state_q == StDisplay);
        current_state = state_q;
        busy          = (state_q inside {StCapture, StSend, StPe, StSa3, StSa2});
        done          = done_q;
        error_code    = err_q;
        mismatch      = mismatch_q;
        cycles_PE     = cyc_pe_q;
        cycles_3x3    = cyc_3_q;
        cycles_2x2    = cyc_2_q;
    end

endmodule
